// File: rtl/collision_engine.sv
// collision_engine: runs up to five tetromino collision checks against the board RAM.
// Checks are serialised into one read stream (one RAM read per cycle). Each read carries
// a tag so returning data is attributed to the right check regardless of RAM latency.
module collision_engine #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 24,
  parameter int XW      = 5,
  parameter int YW      = 6,
  parameter int ADDR_W  = 8,
  parameter int CELL_W  = 6,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [4:0]        check_mask,
  input  logic [XW-1:0]     x_anchor,
  input  logic [YW-1:0]     y_anchor,
  input  logic [7:0]        off_x,
  input  logic [7:0]        off_y,
  input  logic [7:0]        cw_x,
  input  logic [7:0]        cw_y,
  input  logic [7:0]        ccw_x,
  input  logic [7:0]        ccw_y,
  input  logic [CELL_W-1:0] ram_q,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              busy,
  output logic              done,
  output logic [4:0]        collides
);

  localparam int TXW   = XW + 2;
  localparam int TYW   = YW + 2;
  localparam int TAG_W = 5;  // {valid, check index[2:0], out-of-bounds}

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]        state_r;
  logic [4:0]        rem_r;        // checks not yet fully issued, current one included
  logic [1:0]        k_r;          // cell index of the last issued read
  logic [1:0]        drain_cnt_r;
  logic [XW-1:0]     x_r;
  logic [YW-1:0]     y_r;
  logic [7:0]        off_x_r, off_y_r, cw_x_r, cw_y_r, ccw_x_r, ccw_y_r;
  logic [ADDR_W-1:0] ram_addr_r;
  logic              busy_r;
  logic              done_r;
  logic [4:0]        collides_r;
  logic [TAG_W-1:0]  tag_r [0:RAM_LAT];

  logic              issue_s;
  logic [2:0]        iss_chk_s;
  logic [1:0]        iss_k_s;
  logic [4:0]        rem_nxt_s;
  logic [4:0]        rem_clr_s;
  logic [XW-1:0]     src_x_s;
  logic [YW-1:0]     src_y_s;
  logic [7:0]        src_off_x_s, src_off_y_s, src_cw_x_s, src_cw_y_s, src_ccw_x_s, src_ccw_y_s;
  logic [7:0]        sel_ox_s;
  logic [7:0]        sel_oy_s;
  logic [ADDR_W:0]   tgt_s;        // {out-of-bounds, address}
  logic [TAG_W-1:0]  ret_tag_s;

  // Index of the lowest set bit (0 when none set).
  function automatic logic [2:0] lowest_idx(input logic [4:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (m[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Target cell of one piece cell for one check: returns {oob, address}; address is 0 when oob.
  function automatic logic [ADDR_W:0] cell_target(
    input logic [2:0]    chk,
    input logic [1:0]    k,
    input logic [XW-1:0] x,
    input logic [YW-1:0] y,
    input logic [7:0]    ox_v,
    input logic [7:0]    oy_v
  );
    logic [1:0]            ox;
    logic [1:0]            oy;
    logic signed [TXW-1:0] tx;
    logic signed [TYW-1:0] ty;
    logic                  oob;
    logic [ADDR_W-1:0]     addr;
    ox = ox_v[{k, 1'b0} +: 2];
    oy = oy_v[{k, 1'b0} +: 2];
    tx = $signed({2'b00, x}) + $signed({{(TXW-2){1'b0}}, ox});
    ty = $signed({2'b00, y}) + $signed({{(TYW-2){1'b0}}, oy});
    case (chk)
      3'd0:    tx = tx - $signed({{(TXW-1){1'b0}}, 1'b1});
      3'd1:    tx = tx + $signed({{(TXW-1){1'b0}}, 1'b1});
      3'd2:    ty = ty + $signed({{(TYW-1){1'b0}}, 1'b1});
      default: tx = tx;
    endcase
    // A negative tx also lands above BOARD_W when viewed unsigned; the sign test keeps intent explicit.
    oob = tx[TXW-1] || ($unsigned(tx) >= TXW'(BOARD_W)) || ($unsigned(ty) >= TYW'(BOARD_H));
    if (oob) begin
      addr = {ADDR_W{1'b0}};
    end else begin
      addr = ADDR_W'($unsigned(ty)) * ADDR_W'(BOARD_W) + ADDR_W'($unsigned(tx));
    end
    return {oob, addr};
  endfunction

  // Choose the next cell to issue: the first cell on an accepted start, else the RUN successor.
  always_comb begin
    issue_s   = 1'b0;
    iss_chk_s = 3'd0;
    iss_k_s   = 2'd0;
    rem_nxt_s = rem_r;
    rem_clr_s = rem_r & (rem_r - 5'd1);
    case (state_r)
      ST_IDLE: begin
        if (start && (check_mask != 5'd0)) begin
          issue_s   = 1'b1;
          iss_chk_s = lowest_idx(check_mask);
          iss_k_s   = 2'd0;
          rem_nxt_s = check_mask;
        end else begin
          issue_s   = 1'b0;
        end
      end
      ST_RUN: begin
        if (k_r == 2'd3) begin
          rem_nxt_s = rem_clr_s;
          if (rem_clr_s != 5'd0) begin
            issue_s   = 1'b1;
            iss_chk_s = lowest_idx(rem_clr_s);
            iss_k_s   = 2'd0;
          end else begin
            issue_s   = 1'b0;
          end
        end else begin
          issue_s   = 1'b1;
          iss_chk_s = lowest_idx(rem_r);
          iss_k_s   = k_r + 2'd1;
        end
      end
      default: begin
        issue_s = 1'b0;
      end
    endcase
  end

  // Operand source: live inputs on the accepting cycle, latched copies while running.
  always_comb begin
    if (state_r == ST_IDLE) begin
      src_x_s     = x_anchor;
      src_y_s     = y_anchor;
      src_off_x_s = off_x;
      src_off_y_s = off_y;
      src_cw_x_s  = cw_x;
      src_cw_y_s  = cw_y;
      src_ccw_x_s = ccw_x;
      src_ccw_y_s = ccw_y;
    end else begin
      src_x_s     = x_r;
      src_y_s     = y_r;
      src_off_x_s = off_x_r;
      src_off_y_s = off_y_r;
      src_cw_x_s  = cw_x_r;
      src_cw_y_s  = cw_y_r;
      src_ccw_x_s = ccw_x_r;
      src_ccw_y_s = ccw_y_r;
    end
  end

  // Offset set per check: rotations use the neighbouring rotation's offsets.
  always_comb begin
    case (iss_chk_s)
      3'd3: begin
        sel_ox_s = src_cw_x_s;
        sel_oy_s = src_cw_y_s;
      end
      3'd4: begin
        sel_ox_s = src_ccw_x_s;
        sel_oy_s = src_ccw_y_s;
      end
      default: begin
        sel_ox_s = src_off_x_s;
        sel_oy_s = src_off_y_s;
      end
    endcase
  end

  assign tgt_s     = cell_target(iss_chk_s, iss_k_s, src_x_s, src_y_s, sel_ox_s, sel_oy_s);
  assign ret_tag_s = tag_r[RAM_LAT];

  // Request FSM, operand latches and the registered read address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      rem_r       <= 5'd0;
      k_r         <= 2'd0;
      drain_cnt_r <= 2'd0;
      x_r         <= {XW{1'b0}};
      y_r         <= {YW{1'b0}};
      off_x_r     <= 8'd0;
      off_y_r     <= 8'd0;
      cw_x_r      <= 8'd0;
      cw_y_r      <= 8'd0;
      ccw_x_r     <= 8'd0;
      ccw_y_r     <= 8'd0;
      ram_addr_r  <= {ADDR_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      rem_r      <= rem_nxt_s;
      k_r        <= issue_s ? iss_k_s : k_r;
      ram_addr_r <= issue_s ? tgt_s[ADDR_W-1:0] : {ADDR_W{1'b0}};
      done_r     <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            x_r     <= x_anchor;
            y_r     <= y_anchor;
            off_x_r <= off_x;
            off_y_r <= off_y;
            cw_x_r  <= cw_x;
            cw_y_r  <= cw_y;
            ccw_x_r <= ccw_x;
            ccw_y_r <= ccw_y;
            busy_r  <= 1'b1;
            if (check_mask != 5'd0) begin
              state_r <= ST_RUN;
            end else begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (!issue_s) begin
            state_r     <= ST_DRAIN;
            drain_cnt_r <= 2'd0;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt_r == 2'(RAM_LAT - 1)) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end else begin
            drain_cnt_r <= drain_cnt_r + 2'd1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Tag shift register: each tag reaches the end exactly when its read data is on ram_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= RAM_LAT; i++) begin
        tag_r[i] <= {TAG_W{1'b0}};
      end
    end else begin
      tag_r[0] <= {issue_s, iss_chk_s, tgt_s[ADDR_W]};
      for (int i = 1; i <= RAM_LAT; i++) begin
        tag_r[i] <= tag_r[i-1];
      end
    end
  end

  // Per-check blocked flags: cleared on accept, only ever set by returning tagged reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      collides_r <= 5'd0;
    end else if ((state_r == ST_IDLE) && start) begin
      collides_r <= 5'd0;
    end else if (ret_tag_s[4] && (ret_tag_s[0] || (|ram_q))) begin
      collides_r <= collides_r | (5'd1 << ret_tag_s[3:1]);
    end else begin
      collides_r <= collides_r;
    end
  end

  assign ram_addr = ram_addr_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign collides = collides_r;

endmodule

// File: tb/tb_collision_engine.sv
// Testbench for collision_engine: two instances (RAM_LAT=1 and 2) share stimulus and board
// contents; results are compared against a cell-by-cell reference model and hand vectors.
module tb_collision_engine;

  localparam int BW = 10;
  localparam int BH = 24;

  typedef struct {
    logic [4:0] mask;
    logic [4:0] x;
    logic [5:0] y;
    logic [7:0] offx;
    logic [7:0] offy;
    logic [7:0] cwx;
    logic [7:0] cwy;
    logic [7:0] ccwx;
    logic [7:0] ccwy;
    int         occ;
    logic [5:0] occ_val;
    logic [4:0] exp;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       start;
  logic [4:0] check_mask;
  logic [4:0] x_anchor;
  logic [5:0] y_anchor;
  logic [7:0] off_x, off_y, cw_x, cw_y, ccw_x, ccw_y;
  logic [5:0] q1, q2, q2_s;
  logic [7:0] addr1, addr2;
  logic       busy1, busy2, done1, done2;
  logic [4:0] col1, col2;

  logic [5:0] mem [0:255];
  int         exp_q[$];
  int         tests;
  int         fails;
  vec_t       tab [12];

  collision_engine #(.RAM_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .check_mask(check_mask),
    .x_anchor(x_anchor), .y_anchor(y_anchor),
    .off_x(off_x), .off_y(off_y), .cw_x(cw_x), .cw_y(cw_y), .ccw_x(ccw_x), .ccw_y(ccw_y),
    .ram_q(q1), .ram_addr(addr1), .busy(busy1), .done(done1), .collides(col1)
  );

  collision_engine #(.RAM_LAT(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .check_mask(check_mask),
    .x_anchor(x_anchor), .y_anchor(y_anchor),
    .off_x(off_x), .off_y(off_y), .cw_x(cw_x), .cw_y(cw_y), .ccw_x(ccw_x), .ccw_y(ccw_y),
    .ram_q(q2), .ram_addr(addr2), .busy(busy2), .done(done2), .collides(col2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Board RAM models with one and two cycles of read latency.
  always @(posedge clk) q1 <= mem[addr1];
  always @(posedge clk) begin
    q2_s <= mem[addr2];
    q2   <= q2_s;
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: walk the checks in order, each piece cell resolved with plain integer arithmetic.
  function automatic logic [4:0] model(input vec_t v);
    logic [4:0] col;
    logic [7:0] sx, sy;
    int ox, oy, tx, ty;
    col = 5'd0;
    exp_q.delete();
    for (int c = 0; c < 5; c++) begin
      if (v.mask[c]) begin
        sx = (c == 3) ? v.cwx : (c == 4) ? v.ccwx : v.offx;
        sy = (c == 3) ? v.cwy : (c == 4) ? v.ccwy : v.offy;
        for (int k = 0; k < 4; k++) begin
          ox = int'(sx[2*k +: 2]);
          oy = int'(sy[2*k +: 2]);
          tx = int'(v.x) + ox + ((c == 0) ? -1 : (c == 1) ? 1 : 0);
          ty = int'(v.y) + oy + ((c == 2) ? 1 : 0);
          if (tx < 0 || tx >= BW || ty >= BH) begin
            col[c] = 1'b1;
            exp_q.push_back(0);
          end else begin
            exp_q.push_back(ty * BW + tx);
            if (mem[ty * BW + tx] != 6'd0) col[c] = 1'b1;
          end
        end
      end
    end
    return col;
  endfunction

  task automatic drive(input vec_t v);
    check_mask = v.mask;
    x_anchor   = v.x;
    y_anchor   = v.y;
    off_x      = v.offx;
    off_y      = v.offy;
    cw_x       = v.cwx;
    cw_y       = v.cwy;
    ccw_x      = v.ccwx;
    ccw_y      = v.ccwy;
  endtask

  task automatic load_board(input vec_t v);
    for (int i = 0; i < 256; i++) mem[i] = 6'd0;
    if (v.occ >= 0) mem[v.occ] = v.occ_val;
  endtask

  // One request on both instances: latency, single done pulse, address stream, result.
  task automatic run_txn(input vec_t v, input logic [4:0] exp, input int restart_at, input string name);
    int n, lat1, lat2, d1, d2, first1, first2, bad, win;
    void'(model(v));
    n      = $countones(v.mask);
    lat1   = (n == 0) ? 1 : 4 * n + 2;
    lat2   = (n == 0) ? 1 : 4 * n + 3;
    win    = 4 * n + 8;
    d1     = 0;
    d2     = 0;
    first1 = -1;
    first2 = -1;
    bad    = 0;
    @(negedge clk);
    drive(v);
    start = 1'b1;
    for (int j = 1; j <= win; j++) begin
      @(negedge clk);
      if (done1) begin d1++; if (first1 < 0) first1 = j; end
      if (done2) begin d2++; if (first2 < 0) first2 = j; end
      if (j <= 4 * n) begin
        if (addr1 !== 8'(exp_q[j-1])) bad++;
        if (addr2 !== 8'(exp_q[j-1])) bad++;
      end
      if (j == 1) begin
        if (n > 0) check({name, " busy"}, int'(busy1 & busy2), 1);
        check_mask = 5'($urandom);
        x_anchor   = 5'($urandom);
        y_anchor   = 6'($urandom);
        off_x      = 8'($urandom);
        cw_x       = 8'($urandom);
        ccw_y      = 8'($urandom);
      end
      start = (restart_at == j) ? 1'b1 : 1'b0;
    end
    check({name, " lat1"}, first1, lat1);
    check({name, " lat2"}, first2, lat2);
    check({name, " ndone"}, d1 * 10 + d2, 11);
    check({name, " col1"}, int'(col1), int'(exp));
    check({name, " col2"}, int'(col2), int'(exp));
    check({name, " addrseq"}, bad, 0);
    check({name, " idle"}, int'(busy1 | busy2), 0);
  endtask

  task automatic reset_mid_run();
    int d;
    load_board(tab[1]);
    @(negedge clk);
    drive(tab[1]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst precol", int'(col1), 1);
    reset = 1'b1;
    #1;
    check("rst busy", int'({busy1, busy2}), 0);
    check("rst done", int'({done1, done2}), 0);
    check("rst col", int'({col1, col2}), 0);
    check("rst addr", int'({addr1, addr2}), 0);
    @(negedge clk);
    reset = 1'b0;
    d = 0;
    repeat (12) begin
      @(negedge clk);
      if (done1 || done2 || busy1 || busy2) d++;
    end
    check("rst quiet", d, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    logic [4:0] e;
    tests = 0;
    fails = 0;
    //           mask      x      y      offx   offy   cwx    cwy    ccwx   ccwy   occ  val    exp
    tab[0]  = '{5'b11111, 5'd4, 6'd0,  8'h44, 8'h50, 8'h44, 8'h50, 8'h44, 8'h50, -1,  6'h00, 5'b00000};
    tab[1]  = '{5'b00001, 5'd0, 6'd0,  8'h44, 8'h50, 8'h44, 8'h50, 8'h44, 8'h50, -1,  6'h00, 5'b00001};
    tab[2]  = '{5'b00010, 5'd8, 6'd0,  8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, -1,  6'h00, 5'b00010};
    tab[3]  = '{5'b00100, 5'd5, 6'd9,  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 105, 6'h20, 5'b00100};
    tab[4]  = '{5'b00100, 5'd5, 6'd8,  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 105, 6'h20, 5'b00000};
    tab[5]  = '{5'b00100, 5'd2, 6'd23, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, -1,  6'h00, 5'b00100};
    tab[6]  = '{5'b01010, 5'd4, 6'd0,  8'h44, 8'h50, 8'h00, 8'h00, 8'h00, 8'h00, 4,   6'h01, 5'b01000};
    tab[7]  = '{5'b00000, 5'd3, 6'd3,  8'h44, 8'h50, 8'h44, 8'h50, 8'h44, 8'h50, -1,  6'h00, 5'b00000};
    tab[8]  = '{5'b10000, 5'd9, 6'd0,  8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, -1,  6'h00, 5'b10000};
    tab[9]  = '{5'b00011, 5'd3, 6'd5,  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 52,  6'h08, 5'b00001};
    tab[10] = '{5'b11111, 5'd0, 6'd22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, -1,  6'h00, 5'b00001};
    tab[11] = '{5'b11000, 5'd3, 6'd2,  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC0, 53,  6'h3F, 5'b10000};

    for (int i = 0; i < 256; i++) mem[i] = 6'd0;
    reset = 1'b1;
    start = 1'b0;
    drive(tab[7]);
    repeat (3) @(negedge clk);
    check("reset addr", int'({addr1, addr2}), 0);
    check("reset busy", int'({busy1, busy2}), 0);
    check("reset done", int'({done1, done2}), 0);
    check("reset col", int'({col1, col2}), 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      load_board(tab[i]);
      run_txn(tab[i], tab[i].exp, 0, $sformatf("vec%0d", i));
    end

    // A start while busy must be dropped: exactly one done and the first request's result.
    load_board(tab[6]);
    run_txn(tab[6], tab[6].exp, 3, "busy_start");
    load_board(tab[7]);
    run_txn(tab[7], tab[7].exp, 1, "busy_start_n0");

    reset_mid_run();
    load_board(tab[0]);
    run_txn(tab[0], tab[0].exp, 0, "after_reset");

    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 256; i++) begin
        mem[i] = (i < BW * BH && $urandom_range(0, 3) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      end
      v.mask = 5'($urandom);
      v.x    = 5'($urandom_range(0, 11));
      v.y    = 6'($urandom_range(0, 25));
      v.offx = 8'($urandom);
      v.offy = 8'($urandom);
      v.cwx  = 8'($urandom);
      v.cwy  = 8'($urandom);
      v.ccwx = 8'($urandom);
      v.ccwy = 8'($urandom);
      v.occ  = -1;
      v.occ_val = 6'd0;
      e = model(v);
      v.exp = e;
      run_txn(v, e, (v.mask != 5'd0) ? int'($urandom_range(0, 3)) : 0, $sformatf("rnd%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
